// File: rtl/kmac_msg_packer_pkg.sv
// kmac_msg_packer_pkg: shared widths and the sparse packer FSM encoding.
package kmac_msg_packer_pkg;
    localparam int MsgWidth = 64;
    localparam int MsgStrbW = MsgWidth / 8;
    typedef enum logic [4:0] {
        StPack  = 5'b01101,
        StFlush = 5'b10011,
        StDrain = 5'b00110,
        StError = 5'b11000
    } packer_st_e;
endpackage

// File: rtl/kmac_msg_packer_if.sv
// kmac_msg_packer_if: message beat input, packed-word output and process/status bundle.
interface kmac_msg_packer_if #(
    parameter int EnMasking = 0,
    parameter int InW       = 32,
    parameter int Depth     = 4
);
    import kmac_msg_packer_pkg::*;
    localparam int Share  = EnMasking ? 2 : 1;
    localparam int DepthW = $clog2(Depth + 1);
    logic                               in_valid_i;
    logic [Share-1:0][InW-1:0]          in_data_i;
    logic [InW/8-1:0]                   in_strb_i;
    logic                               in_ready_o;
    logic                               process_i;
    logic                               fifo_valid_o;
    logic [Share-1:0][MsgWidth-1:0]     fifo_data_o;
    logic [MsgStrbW-1:0]                fifo_strb_o;
    logic                               fifo_ready_i;
    logic                               process_o;
    logic [DepthW-1:0]                  fifo_depth_o;
    logic                               err_o;
    modport master (
        output in_valid_i, in_data_i, in_strb_i, process_i, fifo_ready_i,
        input  in_ready_o, fifo_valid_o, fifo_data_o, fifo_strb_o, process_o, fifo_depth_o, err_o
    );
    modport slave (
        input  in_valid_i, in_data_i, in_strb_i, process_i, fifo_ready_i,
        output in_ready_o, fifo_valid_o, fifo_data_o, fifo_strb_o, process_o, fifo_depth_o, err_o
    );
endinterface

// File: rtl/kmac_msg_packer_fifo.sv
// kmac_msg_packer_fifo: synchronous show-ahead FIFO holding packed words with their strobes.
module kmac_msg_packer_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    input  logic [Width-1:0]           wdata_i,
    output logic                       rvalid_o,
    input  logic                       rready_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth+1)-1:0] depth_o
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push, pop;
    assign wready_o = cnt_q < CntW'(Depth);
    assign rvalid_o = cnt_q != '0;
    assign rdata_o  = mem_q[rptr_q];
    assign depth_o  = cnt_q;
    assign push     = wvalid_i && wready_o;
    assign pop      = rvalid_o && rready_i;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = wdata_i;
        wptr_d = push ? ((wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d = pop ? ((rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1) : rptr_q;
        cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/kmac_msg_packer.sv
// kmac_msg_packer: packs byte-strobed message beats little-endian into words, buffers them,
// and on process_i flushes the partial word and forwards process_o once the FIFO drains.
module kmac_msg_packer
    import kmac_msg_packer_pkg::*;
#(
    parameter int EnMasking = 0,
    parameter int InW       = 32,
    parameter int Depth     = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    input logic               clear_i,
    kmac_msg_packer_if.slave  bus
);
    localparam int Share  = EnMasking ? 2 : 1;
    localparam int BeatB  = InW / 8;
    localparam int PosW   = $clog2(MsgStrbW);
    localparam int CntW   = $clog2(BeatB + 1);
    localparam int EntW   = Share * MsgWidth + MsgStrbW;
    localparam int DepthW = $clog2(Depth + 1);
    typedef logic [Share-1:0][MsgWidth-1:0] word_t;
    packer_st_e          st_q, st_d;
    logic [PosW-1:0]     pos_q, pos_d;
    word_t               stage_q, stage_d, merged;
    logic                err_q, err_d;
    logic [InW-1:0]      bmask;
    logic [CntW-1:0]     n;
    logic [PosW:0]       sum;
    logic                contig, accept, wr_beat, full_word, push_full, push_flush;
    logic [MsgStrbW-1:0] flush_strb;
    logic                f_wvalid, f_wready, f_rvalid, f_rready;
    logic [EntW-1:0]     f_wdata, f_rdata;
    logic [DepthW-1:0]   f_depth;
    // Bytes at and above pos are always zero, so merging a beat is a shifted OR.
    always_comb begin
        for (int i = 0; i < InW; i++) bmask[i] = bus.in_strb_i[i/8];
        for (int s = 0; s < Share; s++)
            merged[s] = stage_q[s] | (MsgWidth'(bus.in_data_i[s] & bmask) << {pos_q, 3'b000});
    end
    assign n          = CntW'($countones(bus.in_strb_i));
    assign contig     = (bus.in_strb_i & (bus.in_strb_i + BeatB'(1))) == '0;
    assign sum        = (PosW+1)'(pos_q) + (PosW+1)'(n);
    assign accept     = bus.in_valid_i && bus.in_ready_o;
    assign wr_beat    = accept && contig && (n != '0);
    assign full_word  = sum >= (PosW+1)'(MsgStrbW);
    assign push_full  = wr_beat && full_word;
    assign push_flush = (st_q == StFlush) && (pos_q != '0) && f_wready;
    assign flush_strb = (MsgStrbW'(1) << pos_q) - 1'b1;
    assign f_wvalid   = push_full || push_flush;
    assign f_wdata    = push_full ? {merged, {MsgStrbW{1'b1}}} : {stage_q, flush_strb};
    always_comb begin
        st_d           = st_q;
        bus.in_ready_o = 1'b0;
        bus.process_o  = 1'b0;
        case (st_q)
            StPack: begin
                bus.in_ready_o = f_wready;
                st_d = bus.process_i ? StFlush : StPack;
            end
            StFlush: st_d = (pos_q == '0 || f_wready) ? StDrain : StFlush;
            StDrain: begin
                bus.process_o = f_depth == '0;
                st_d = (f_depth == '0) ? StPack : StDrain;
            end
            StError: st_d = StError;
            default: st_d = StError;
        endcase
    end
    always_comb begin
        pos_d   = pos_q;
        stage_d = stage_q;
        if (wr_beat) begin
            pos_d   = full_word ? '0 : sum[PosW-1:0];
            stage_d = full_word ? '0 : merged;
        end
        if (push_flush) begin
            pos_d   = '0;
            stage_d = '0;
        end
        err_d = (accept && !contig) || (bus.process_i && st_q != StPack) || (st_q == StError);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            st_q    <= StPack;
            pos_q   <= '0;
            stage_q <= '0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            pos_q   <= pos_d;
            stage_q <= stage_d;
            err_q   <= err_d;
        end
    end
    assign f_rready                        = bus.fifo_ready_i && (st_q != StError);
    assign bus.fifo_valid_o                = f_rvalid && (st_q != StError);
    assign {bus.fifo_data_o, bus.fifo_strb_o} = f_rdata;
    assign bus.fifo_depth_o                = f_depth;
    assign bus.err_o                       = err_q;
    kmac_msg_packer_fifo #(
        .Width (EntW),
        .Depth (Depth)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (clear_i),
        .wvalid_i (f_wvalid),
        .wready_o (f_wready),
        .wdata_i  (f_wdata),
        .rvalid_o (f_rvalid),
        .rready_i (f_rready),
        .rdata_o  (f_rdata),
        .depth_o  (f_depth)
    );
endmodule

// File: tb/tb_kmac_msg_packer.sv
// tb_kmac_msg_packer: masked packer bench; a byte-queue model predicts every packed word.
module tb_kmac_msg_packer;
    typedef struct packed {
        logic [63:0] d0;
        logic [63:0] d1;
        logic [7:0]  s;
    } word_t;
    logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
    int tests = 0, fails = 0, proc_cnt = 0, err_cnt = 0, pops = 0;
    logic [7:0] stg[$];
    word_t exp_q[$];
    word_t mon_w;
    bit rnd_run = 1'b0;
    always #5 clk = ~clk;
    kmac_msg_packer_if #(.EnMasking(1), .InW(32), .Depth(4)) bus ();
    kmac_msg_packer #(.EnMasking(1), .InW(32), .Depth(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .bus     (bus)
    );
    // Staged bytes become one expected word; share 1 is the byte-wise complement.
    function automatic void model_push();
        word_t w = '0;
        foreach (stg[i]) begin
            w.d0[i*8 +: 8] = stg[i];
            w.d1[i*8 +: 8] = ~stg[i];
            w.s[i] = 1'b1;
        end
        if (stg.size() != 0) exp_q.push_back(w);
        stg.delete();
    endfunction
    always @(negedge clk) begin
        if (!rst && !clear) begin
            if (bus.process_o) proc_cnt++;
            if (bus.err_o) err_cnt++;
            if (bus.fifo_valid_o && bus.fifo_ready_i) begin
                tests++;
                pops++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL word_unexpected: got d0=%h strb=%h, required no word", bus.fifo_data_o[0], bus.fifo_strb_o);
                end else begin
                    mon_w = exp_q.pop_front();
                    if ({bus.fifo_data_o[0], bus.fifo_data_o[1], bus.fifo_strb_o} !== {mon_w.d0, mon_w.d1, mon_w.s}) begin
                        fails++;
                        $display("FAIL word_data: got d0=%h d1=%h strb=%h, required d0=%h d1=%h strb=%h",
                                 bus.fifo_data_o[0], bus.fifo_data_o[1], bus.fifo_strb_o, mon_w.d0, mon_w.d1, mon_w.s);
                    end
                end
            end
        end
    end
    task automatic beat(input logic [31:0] d, input logic [3:0] s);
        bit ok = 1'b0;
        bus.in_valid_i   = 1'b1;
        bus.in_data_i[0] = d;
        bus.in_data_i[1] = ~d;
        bus.in_strb_i    = s;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready_o;
            @(posedge clk);
            #1;
        end
        bus.in_valid_i = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: in_ready_o stayed 0, required 1 within 300 cycles");
        end else if (s == 4'((1 << $countones(s)) - 1)) begin
            for (int b = 0; b < $countones(s); b++) stg.push_back(d[b*8 +: 8]);
            if (stg.size() == 8) model_push();
        end
    endtask
    task automatic send_process(input bit legal);
        bus.process_i = 1'b1;
        @(posedge clk);
        #1;
        bus.process_i = 1'b0;
        if (legal) model_push();
    endtask
    task automatic wait_proc(input int p0);
        for (int i = 0; i < 100 && proc_cnt == p0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests += 4;
        if (bus.fifo_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", bus.fifo_valid_o); end
        if (bus.fifo_depth_o !== 3'd0) begin fails++; $display("FAIL reset_depth: got %0d, required 0", bus.fifo_depth_o); end
        if (bus.err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, required 0", bus.err_o); end
        if (bus.process_o !== 1'b0) begin fails++; $display("FAIL reset_process: got %b, required 0", bus.process_o); end
        @(posedge clk);
        #1;
    endtask
    task automatic test_full_word();
        bus.fifo_ready_i = 1'b1;
        beat(32'h03020100, 4'hF);
        @(negedge clk);
        tests++;
        if (bus.fifo_valid_o !== 1'b0) begin fails++; $display("FAIL t1_half_valid: got %b, required 0", bus.fifo_valid_o); end
        @(posedge clk);
        #1;
        beat(32'h07060504, 4'hF);
        @(negedge clk);
        tests += 2;
        if (bus.fifo_valid_o !== 1'b1) begin fails++; $display("FAIL t1_valid: got %b, required 1", bus.fifo_valid_o); end
        if (bus.fifo_depth_o !== 3'd1) begin fails++; $display("FAIL t1_depth: got %0d, required 1", bus.fifo_depth_o); end
        repeat (3) @(posedge clk);
        #1;
    endtask
    task automatic test_partial_flush();
        int p0, w0;
        beat(32'h44332211, 4'hF);
        beat(32'hA5A56655, 4'h3);
        p0 = proc_cnt;
        w0 = pops;
        send_process(1'b1);
        wait_proc(p0);
        tests += 2;
        if (proc_cnt - p0 != 1) begin fails++; $display("FAIL t2_process: got %0d pulses, required 1", proc_cnt - p0); end
        if (pops - w0 != 1) begin fails++; $display("FAIL t2_words: got %0d words, required 1", pops - w0); end
    endtask
    task automatic test_empty_flush();
        int p0, w0, c;
        p0 = proc_cnt;
        w0 = pops;
        c = 0;
        send_process(1'b1);
        while (proc_cnt == p0 && c < 10) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        tests += 3;
        if (c > 3) begin fails++; $display("FAIL t3_latency: got %0d cycles, required <= 3", c); end
        if (proc_cnt - p0 != 1) begin fails++; $display("FAIL t3_process: got %0d pulses, required 1", proc_cnt - p0); end
        if (pops != w0) begin fails++; $display("FAIL t3_words: got %0d words, required 0", pops - w0); end
    endtask
    task automatic test_backpressure();
        int w0;
        bus.fifo_ready_i = 1'b0;
        w0 = pops;
        fork
            begin
                for (int k = 0; k < 10; k++) beat($urandom, 4'hF);
            end
            begin
                for (int i = 0; i < 200 && bus.fifo_depth_o != 3'd4; i++) @(posedge clk);
                repeat (3) @(posedge clk);
                @(negedge clk);
                tests += 2;
                if (bus.fifo_depth_o !== 3'd4) begin fails++; $display("FAIL t4_depth: got %0d, required 4", bus.fifo_depth_o); end
                if (bus.in_ready_o !== 1'b0) begin fails++; $display("FAIL t4_ready: got %b, required 0", bus.in_ready_o); end
                @(posedge clk);
                #1;
                bus.fifo_ready_i = 1'b1;
            end
        join
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (pops - w0 != 5) begin fails++; $display("FAIL t4_words: got %0d words, required 5", pops - w0); end
    endtask
    task automatic test_errors();
        int e0, p0;
        bus.fifo_ready_i = 1'b1;
        e0 = err_cnt;
        beat($urandom, 4'h3);
        beat($urandom, 4'h5);
        beat($urandom, 4'h3);
        beat($urandom, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (err_cnt - e0 != 1) begin fails++; $display("FAIL t5_strb_err: got %0d err cycles, required 1", err_cnt - e0); end
        bus.fifo_ready_i = 1'b0;
        beat($urandom, 4'h3);
        e0 = err_cnt;
        p0 = proc_cnt;
        send_process(1'b1);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (bus.fifo_depth_o !== 3'd1) begin fails++; $display("FAIL t5_held_depth: got %0d, required 1", bus.fifo_depth_o); end
        @(posedge clk);
        #1;
        send_process(1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus.fifo_ready_i = 1'b1;
        wait_proc(p0);
        tests += 2;
        if (proc_cnt - p0 != 1) begin fails++; $display("FAIL t5_process: got %0d pulses, required 1", proc_cnt - p0); end
        if (err_cnt - e0 != 1) begin fails++; $display("FAIL t5_proc_err: got %0d err cycles, required 1", err_cnt - e0); end
    endtask
    task automatic test_clear();
        bus.fifo_ready_i = 1'b0;
        beat($urandom, 4'hF);
        beat($urandom, 4'hF);
        beat($urandom, 4'h7);
        @(negedge clk);
        tests++;
        if (bus.fifo_depth_o !== 3'd1) begin fails++; $display("FAIL t6_pre_depth: got %0d, required 1", bus.fifo_depth_o); end
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        stg.delete();
        exp_q.delete();
        @(negedge clk);
        tests += 2;
        if (bus.fifo_depth_o !== 3'd0) begin fails++; $display("FAIL t6_depth: got %0d, required 0", bus.fifo_depth_o); end
        if (bus.fifo_valid_o !== 1'b0) begin fails++; $display("FAIL t6_valid: got %b, required 0", bus.fifo_valid_o); end
        @(posedge clk);
        #1;
        bus.fifo_ready_i = 1'b1;
        beat(32'hDDCCBBAA, 4'hF);
        beat(32'h11223344, 4'hF);
        repeat (4) @(posedge clk);
        #1;
    endtask
    task automatic test_random();
        int p0, nb, mx, nn;
        logic [3:0] s;
        rnd_run = 1'b1;
        fork
            while (rnd_run) begin
                @(posedge clk);
                #1;
                bus.fifo_ready_i = 1'($urandom_range(0, 1));
            end
        join_none
        for (int m = 0; m < 6; m++) begin
            nb = $urandom_range(1, 8);
            for (int b = 0; b < nb; b++) begin
                mx = (8 - stg.size()) < 4 ? 8 - stg.size() : 4;
                nn = $urandom_range(0, mx);
                s = 4'((1 << nn) - 1);
                if ($urandom_range(0, 7) == 0) s = 4'hA;
                beat($urandom, s);
            end
            p0 = proc_cnt;
            send_process(1'b1);
            wait_proc(p0);
            tests++;
            if (proc_cnt - p0 != 1) begin fails++; $display("FAIL rnd_process_%0d: got %0d pulses, required 1", m, proc_cnt - p0); end
        end
        rnd_run = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        bus.fifo_ready_i = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
    endtask
    initial begin
        bus.in_valid_i   = 1'b0;
        bus.in_data_i    = '0;
        bus.in_strb_i    = '0;
        bus.process_i    = 1'b0;
        bus.fifo_ready_i = 1'b0;
        test_reset();
        test_full_word();
        test_partial_flush();
        test_empty_flush();
        test_backpressure();
        test_errors();
        test_clear();
        test_random();
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL leftover_words: got %0d undelivered, required 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end
endmodule
